// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory address and captures the decoded R-type fields plus PC+1 into the
// IF/ID pipeline register. Supports global enable, stall, flush and
// branch/jump redirect.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   enable                0 freezes PC and IF/ID
//   stall                 hold PC and IF/ID (overridden by redirect/flush)
//   flush                 squash IF/ID to a bubble
//   redirect, target      taken branch/jump: PC <= target, IF/ID flushed
//   pcAddr                current PC, straight from the PC register
//   memRd..memFunc        decoded fields returned by the instruction memory
//   ifidRd..ifidFunc      registered fields
//   ifidPcNext            registered PC+1 of the captured instruction
//   ifidValid             1 = real instruction, 0 = bubble
module fetch_stage #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned FUNC_W   = 6,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pcAddr,
   input  logic [REG_W-1:0]  memRd,
   input  logic [REG_W-1:0]  memRs,
   input  logic [REG_W-1:0]  memRt,
   input  logic [REG_W-1:0]  memSa,
   input  logic [FUNC_W-1:0] memFunc,
   output logic [REG_W-1:0]  ifidRd,
   output logic [REG_W-1:0]  ifidRs,
   output logic [REG_W-1:0]  ifidRt,
   output logic [REG_W-1:0]  ifidSa,
   output logic [FUNC_W-1:0] ifidFunc,
   output logic [ADDR_W-1:0] ifidPcNext,
   output logic              ifidValid
);

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_plus1;

   logic [REG_W-1:0]  rd_q, rd_d;
   logic [REG_W-1:0]  rs_q, rs_d;
   logic [REG_W-1:0]  rt_q, rt_d;
   logic [REG_W-1:0]  sa_q, sa_d;
   logic [FUNC_W-1:0] func_q, func_d;
   logic [ADDR_W-1:0] pcn_q, pcn_d;
   logic              valid_q, valid_d;

   // PC+1 kept in ADDR_W bits so 15 -> 0 wraps with the carry dropped
   assign pc_plus1 = pc_q + ADDR_W'(1);

   // PC next-state: enable, then redirect (beats stall), then stall, then +1
   always_comb begin
      pc_d = pc_q;
      if (enable) begin
         if (redirect)
            pc_d = target;
         else if (!stall)
            pc_d = pc_plus1;
      end
   end

   // IF/ID next-state: a redirect squashes the instruction fetched this cycle,
   // and flush/redirect beat stall
   always_comb begin
      rd_d    = rd_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      sa_d    = sa_q;
      func_d  = func_q;
      pcn_d   = pcn_q;
      valid_d = valid_q;
      if (enable) begin
         if (flush || redirect) begin
            rd_d    = '0;
            rs_d    = '0;
            rt_d    = '0;
            sa_d    = '0;
            func_d  = '0;
            pcn_d   = '0;
            valid_d = 1'b0;
         end else if (!stall) begin
            rd_d    = memRd;
            rs_d    = memRs;
            rt_d    = memRt;
            sa_d    = memSa;
            func_d  = memFunc;
            pcn_d   = pc_plus1;
            valid_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC_V;
         rd_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         sa_q    <= '0;
         func_q  <= '0;
         pcn_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         sa_q    <= sa_d;
         func_q  <= func_d;
         pcn_q   <= pcn_d;
         valid_q <= valid_d;
      end
   end

   assign pcAddr     = pc_q;
   assign ifidRd     = rd_q;
   assign ifidRs     = rs_q;
   assign ifidRt     = rt_q;
   assign ifidSa     = sa_q;
   assign ifidFunc   = func_q;
   assign ifidPcNext = pcn_q;
   assign ifidValid  = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipeline.
- Holds the program counter and drives the 4-bit address into the instruction memory.
- The memory returns its decoded R-type fields (rd, rs, rt, sa, func) combinationally. This block captures them, together with PC+1, into the IF/ID pipeline register that feeds decode.
- Supports stall, flush and branch/jump redirect.

Parameters:
- ADDR_W, 4, PC / instruction-memory address width (16-word memory).
- REG_W, 5, width of each register-specifier / shift-amount field.
- FUNC_W, 6, width of the function field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global run enable; 0 freezes PC and the IF/ID register.
- stall  in  1  hazard stall from decode; holds PC and the IF/ID register.
- flush  in  1  squashes the IF/ID contents (bubble insert).
- redirect  in  1  taken branch/jump; loads PC from target.
- target  in  ADDR_W  branch/jump target address.
- pcAddr  out  ADDR_W  current PC; drives the instruction-memory address input.
- memRd, memRs, memRt, memSa  in  REG_W each  decoded fields from instruction memory.
- memFunc  in  FUNC_W  function field from instruction memory.
- ifidRd, ifidRs, ifidRt, ifidSa  out  REG_W each  registered fields.
- ifidFunc  out  FUNC_W  registered function field.
- ifidPcNext  out  ADDR_W  registered PC+1 of the captured instruction.
- ifidValid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pcAddr = RESET_PC.
  - All ifid field outputs = 0; ifidPcNext = 0; ifidValid = 0.
  - Effect is immediate, not clock-gated.
  - First capture happens at the first rising edge after reset deasserts.
- pcAddr is the PC register output directly; no combinational path from inputs to pcAddr.
- PC update at each rising edge, in priority order:
  1. enable=0: hold.
  2. redirect=1: PC <= target (overrides stall).
  3. stall=1: hold.
  4. Otherwise: PC <= PC+1, modulo 2^ADDR_W (15 -> 0 wraps silently, no flag).
- IF/ID update at each rising edge, in priority order:
  1. enable=0: hold all.
  2. flush=1 or redirect=1: fields <= 0, ifidPcNext <= 0, ifidValid <= 0. Flush beats stall.
  3. stall=1: hold all, including ifidValid.
  4. Otherwise: capture memRd/memRs/memRt/memSa/memFunc as presented for the current pcAddr; ifidPcNext <= PC+1 (wrapped); ifidValid <= 1.
- Latency:
  - Instruction at address A appears on the ifid outputs one cycle after pcAddr = A.
  - Redirect costs one bubble: the instruction fetched in the redirect cycle is discarded.
  - The target instruction is valid in IF/ID two edges after redirect is sampled.
- Simultaneous events:
  - stall+redirect: PC takes target, IF/ID flushed.
  - stall+flush, no redirect: PC holds, IF/ID flushed.
  - flush alone: PC increments normally.
- Width rule: PC+1 is computed in ADDR_W bits; the carry is discarded.
- No X propagation: memory inputs are only sampled on a capture edge.

Test Plan:
- Reset then 5 free-running cycles with memory word0 = {rd=1, rs=3, rt=2, sa=0, func=0x21}:
  - pcAddr steps 0,1,2,3,4.
  - After first edge: ifidRd=1, ifidRs=3, ifidRt=2, ifidFunc=0x21, ifidPcNext=1, ifidValid=1.
- Run from PC=14 for 3 edges -> pcAddr 14,15,0; ifidPcNext for the PC=15 fetch = 0.
- stall=1 for 3 cycles at PC=5 -> pcAddr stays 5; ifid outputs and ifidValid unchanged; stall drop -> PC 6 next edge.
- redirect=1, target=9, stall=1 at PC=3 -> next edge pcAddr=9, ifidValid=0; following edge captures word9, ifidPcNext=10, ifidValid=1.
- flush=1 alone at PC=7 -> pcAddr=8, ifidValid=0, all fields 0.
- Assert reset asynchronously mid-cycle at PC=11 with ifidValid=1 -> pcAddr=0 and ifidValid=0 before the next clock edge. enable=0 for 2 cycles afterward -> everything frozen.
